irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Interrupt front-end that sits directly upstream of the multicycle CPU control unit.
- Synchronizes and edge-detects external IRQ lines, and holds them pending under a programmable mask.
- At an instruction boundary it selects the highest-priority request and captures EPC/Cause.
- It then pulses irq_take so the control unit loads irq_vector into the PC, and it blocks further takes until eret.

Parameters:
N_IRQ, 8, number of external interrupt lines (1..32)
VEC_BASE, 32'h0000_00C0, handler base address driven on irq_vector

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
irq_in  input  N_IRQ  raw external interrupt lines, asynchronous to clock
mask_wr  input  1  load mask register from mask_data
mask_data  input  N_IRQ  new mask value (1 = enabled)
PC  input  32  address of next instruction to execute (resume address)
instr_boundary  input  1  control unit is in fetch state; an interrupt may be taken
eret  input  1  one-cycle pulse: handler finished, return from interrupt
irq_take  output  1  one-cycle pulse: divert PC to irq_vector
irq_vector  output  32  handler entry address
EPC  output  32  captured resume address
Cause  output  32  bit31 = 1 (interrupt), bits[6:2] = source index, other bits 0
in_service  output  1  a handler is active
pending  output  N_IRQ  latched pending requests

Behaviour:
- One clock; reset is asynchronous and active-low.
- While reset = 0, all state clears immediately: sync flops, pending, mask, EPC, Cause, irq_take = 0, in_service = 0, state = IDLE.
- Reset asserted mid-service drops in_service with no further action.
- Synchronizer: two-flop synchronizer per line, followed by a third flop for edge detection.
  - A rising edge sets pending[i] 3 cycles after irq_in[i] rises.
  - Level-high with no new edge does not re-set pending.
- Mask register:
  - mask_wr = 1 loads mask_data at the clock edge.
  - A take decision on the same edge uses the old mask.
  - Masked bits still latch into pending.
- Selection: req = pending & mask. Lowest index has highest priority; idx = index of lowest set bit of req.
- FSM states: IDLE and SERVICE.
- IDLE:
  - If instr_boundary = 1 and req != 0 at an edge: EPC <= PC, Cause <= {1'b1, 24'b0, idx[4:0], 2'b00}, pending[idx] <= 0, state <= SERVICE.
  - irq_take = 1 for exactly the one cycle following that edge.
  - instr_boundary = 0 with req != 0: hold and wait; no capture.
  - eret in IDLE: ignored.
- SERVICE:
  - in_service = 1. No nesting: no take occurs regardless of req or instr_boundary.
  - Edges keep latching into pending.
  - EPC and Cause hold their values.
  - eret = 1 at an edge: state <= IDLE.
  - The earliest next take is at the following edge, if instr_boundary = 1 and req != 0.
- Simultaneous events:
  - A new edge on line idx in the same cycle that pending[idx] is cleared by a take: set wins, pending[idx] stays 1.
  - eret and mask_wr in the same cycle: both take effect.
- irq_vector is combinational from the registered Cause index (see optional feature). It equals VEC_BASE after reset.
- Latency:
  - irq_in rise to pending = 3 cycles.
  - Boundary edge to irq_take high = 1 cycle.
  - irq_take lasts 1 cycle.

Optional Feature:
- Macro IRQ_VECTORED_EN.
- Defined: irq_vector = VEC_BASE + (Cause[6:2] << 4), giving a 16-byte slot per source.
- Undefined: irq_vector = VEC_BASE for all sources; the handler decodes Cause.

Test Plan:
- Reset default: release reset, pulse irq_in[2] with mask = 0 -> pending = 8'h04, irq_take never asserts, in_service = 0.
- Basic take: mask = 8'hFF, irq_in[3] rises, instr_boundary = 1 with PC = 32'h0000_0040 -> pending[3] after 3 cycles; one cycle after the next boundary edge irq_take = 1 for 1 cycle, EPC = 32'h40, Cause = 32'h8000_000C, in_service = 1, pending[3] = 0.
- Priority: irq_in[5] and irq_in[1] rise together, mask = 8'hFF -> first take has Cause[6:2] = 1. After eret and the next boundary, the second take has Cause[6:2] = 5.
- No nesting: in SERVICE, raise irq_in[0] with boundary held at 1 -> no irq_take, pending[0] = 1. Pulse eret -> take occurs at the next boundary edge with Cause = 32'h8000_0000.
- Async reset mid-service: in SERVICE, drop reset asynchronously between clock edges -> in_service, EPC, Cause and pending read 0 before the next clock edge.
- IRQ_VECTORED_EN defined, irq_in[2] taken -> irq_vector = 32'h0000_00E0. Undefined -> irq_vector = 32'h0000_00C0.

Source files
------------

// File: rtl/irq_controller.sv
// Interrupt front-end: synchronizes and edge-detects IRQ lines, latches pending under a mask,
// takes the lowest-index request at an instruction boundary. Define IRQ_VECTORED_EN for per-source vectors.
module irq_controller #(
  parameter int          N_IRQ    = 8,
  parameter logic [31:0] VEC_BASE = 32'h0000_00C0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_wr,
  input  logic [N_IRQ-1:0] mask_data,
  input  logic [31:0]      PC,
  input  logic             instr_boundary,
  input  logic             eret,
  output logic             irq_take,
  output logic [31:0]      irq_vector,
  output logic [31:0]      EPC,
  output logic [31:0]      Cause,
  output logic             in_service,
  output logic [N_IRQ-1:0] pending
);

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_IRQ-1:0] r_sync1;
  logic [N_IRQ-1:0] r_sync2;
  logic [N_IRQ-1:0] r_sync3;
  logic [N_IRQ-1:0] r_pending;
  logic [N_IRQ-1:0] r_mask;
  logic [N_IRQ-1:0] w_edge;
  logic [N_IRQ-1:0] w_req;
  logic [N_IRQ-1:0] w_clr;
  logic [4:0]       w_idx;
  logic             w_take;
  logic             r_take;
  logic [31:0]      r_epc;
  logic [31:0]      r_cause;

  // r_sync3 is a delayed copy of the synchronized level, used only for edge detection.
  assign w_edge = r_sync2 & ~r_sync3;
  assign w_req  = r_pending & r_mask;

  // Scanning downward leaves the lowest set index as the winner.
  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    w_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_req[i]) w_idx = 5'(i);
    end
  end

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      w_clr[i] = w_take && (w_idx == 5'(i));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      IDLE: begin
        if (instr_boundary && (|w_req)) begin
          w_take      = 1'b1;
          w_state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (eret) w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_sync3   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_take    <= 1'b0;
      r_epc     <= '0;
      r_cause   <= '0;
    end else begin
      r_sync1   <= irq_in;
      r_sync2   <= r_sync1;
      r_sync3   <= r_sync2;
      // A fresh edge on the line being taken wins over the clear.
      r_pending <= (r_pending & ~w_clr) | w_edge;
      if (mask_wr) r_mask <= mask_data;
      r_take    <= w_take;
      if (w_take) begin
        r_epc   <= PC;
        r_cause <= {1'b1, 24'b0, w_idx, 2'b00};
      end
    end
  end

  assign irq_take   = r_take;
  assign EPC        = r_epc;
  assign Cause      = r_cause;
  assign in_service = (r_state == SERVICE);
  assign pending    = r_pending;

`ifdef IRQ_VECTORED_EN
  assign irq_vector = VEC_BASE + {23'd0, r_cause[6:2], 4'd0};
`else
  assign irq_vector = VEC_BASE;
`endif

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the interrupt rules.
module tb_irq_controller;
  localparam int          N   = 8;
  localparam logic [31:0] VEC = 32'h0000_00C0;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  irq_in = '0;
  logic          mask_wr = 1'b0;
  logic [N-1:0]  mask_data = '0;
  logic [31:0]   PC = '0;
  logic          instr_boundary = 1'b0;
  logic          eret = 1'b0;
  logic          irq_take;
  logic [31:0]   irq_vector;
  logic [31:0]   EPC;
  logic [31:0]   Cause;
  logic          in_service;
  logic [N-1:0]  pending;

  int checks   = 0;
  int failures = 0;

  irq_controller #(.N_IRQ(N), .VEC_BASE(VEC)) dut (
    .clock(clock), .reset(reset), .irq_in(irq_in), .mask_wr(mask_wr),
    .mask_data(mask_data), .PC(PC), .instr_boundary(instr_boundary), .eret(eret),
    .irq_take(irq_take), .irq_vector(irq_vector), .EPC(EPC), .Cause(Cause),
    .in_service(in_service), .pending(pending)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: history of sampled irq_in values, newest first.
  logic [N-1:0] m_pend, m_mask;
  logic         m_svc, m_take;
  logic [31:0]  m_epc, m_cause;
  logic [N-1:0] m_hist[$];

  task automatic m_clear();
    m_pend = '0; m_mask = '0; m_svc = 1'b0; m_take = 1'b0;
    m_epc = '0; m_cause = '0;
    m_hist.delete();
    repeat (3) m_hist.push_back('0);
  endtask

  // An edge is recognized once the line was low three samples back and high two samples back.
  task automatic m_update();
    logic [N-1:0] req, lsb, rise, clr;
    int           idx;
    bit           take;
    if (!reset) begin
      m_clear();
      return;
    end
    rise = m_hist[1] & ~m_hist[2];
    req  = m_pend & m_mask;
    take = !m_svc && instr_boundary && (req != 0);
    clr  = '0;
    if (take) begin
      lsb     = req & (~req + 8'd1);
      idx     = $clog2(lsb);
      clr     = lsb;
      m_epc   = PC;
      m_cause = 32'h8000_0000 | (idx << 2);
    end
    m_pend = (m_pend & ~clr) | rise;
    if (mask_wr) m_mask = mask_data;
    if (take) m_svc = 1'b1;
    else if (eret) m_svc = 1'b0;
    m_take = take;
    m_hist.push_front(irq_in);
    void'(m_hist.pop_back());
  endtask

  function automatic logic [31:0] m_vec();
`ifdef IRQ_VECTORED_EN
    return VEC + 32'(m_cause[6:2]) * 32'd16;
`else
    return VEC;
`endif
  endfunction

  task automatic tick();
    m_update();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; irq_in = '0; mask_wr = 1'b0; mask_data = '0;
    PC = '0; instr_boundary = 1'b0; eret = 1'b0;
    m_clear();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic set_mask(input logic [N-1:0] m);
    mask_wr = 1'b1; mask_data = m;
    tick();
    mask_wr = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    checks++; if ({irq_take, in_service, pending, EPC, Cause} !== '0) begin
      failures++; $display("FAIL reset_state: take=%b svc=%b pend=%h epc=%h cause=%h want all 0",
                           irq_take, in_service, pending, EPC, Cause); end
    checks++; if (irq_vector !== VEC) begin
      failures++; $display("FAIL reset_vector: got %h want %h", irq_vector, VEC); end
    do_reset();
    irq_in[2] = 1'b1;
    tick(); tick();
    irq_in[2] = 1'b0;
    instr_boundary = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (irq_take !== 1'b0) begin
        failures++; $display("FAIL reset_masked_take: cycle %0d got %b want 0", i, irq_take); end
    end
    checks++; if (pending !== 8'h04) begin
      failures++; $display("FAIL reset_pending: got %h want 04", pending); end
    checks++; if (in_service !== 1'b0) begin
      failures++; $display("FAIL reset_in_service: got %b want 0", in_service); end
  endtask

  task automatic test_basic_take();
    do_reset();
    set_mask(8'hFF);
    irq_in[3] = 1'b1;
    tick(); tick();
    checks++; if (pending !== 8'h00) begin
      failures++; $display("FAIL basic_early_pending: got %h want 00", pending); end
    tick();
    checks++; if (pending !== 8'h08) begin
      failures++; $display("FAIL basic_pending: got %h want 08", pending); end
    instr_boundary = 1'b1; PC = 32'h0000_0040;
    tick();
    checks++; if (irq_take !== 1'b1) begin
      failures++; $display("FAIL basic_take: got %b want 1", irq_take); end
    checks++; if (EPC !== 32'h40 || Cause !== 32'h8000_000C) begin
      failures++; $display("FAIL basic_capture: epc=%h cause=%h want 00000040 8000000c", EPC, Cause); end
    checks++; if (in_service !== 1'b1 || pending !== 8'h00) begin
      failures++; $display("FAIL basic_service: svc=%b pend=%h want 1 00", in_service, pending); end
    tick();
    checks++; if (irq_take !== 1'b0 || in_service !== 1'b1) begin
      failures++; $display("FAIL basic_take_width: take=%b svc=%b want 0 1", irq_take, in_service); end
    instr_boundary = 1'b0; eret = 1'b1;
    tick();
    eret = 1'b0; irq_in = '0;
    checks++; if (in_service !== 1'b0) begin
      failures++; $display("FAIL basic_eret: got %b want 0", in_service); end
  endtask

  task automatic test_priority();
    do_reset();
    set_mask(8'hFF);
    irq_in = 8'h22;
    repeat (3) tick();
    instr_boundary = 1'b1;
    tick();
    checks++; if (irq_take !== 1'b1 || Cause !== 32'h8000_0004) begin
      failures++; $display("FAIL prio_first: take=%b cause=%h want 1 80000004", irq_take, Cause); end
    eret = 1'b1;
    tick();
    eret = 1'b0;
    checks++; if (irq_take !== 1'b0 || in_service !== 1'b0) begin
      failures++; $display("FAIL prio_eret: take=%b svc=%b want 0 0", irq_take, in_service); end
    tick();
    checks++; if (irq_take !== 1'b1 || Cause !== 32'h8000_0014) begin
      failures++; $display("FAIL prio_second: take=%b cause=%h want 1 80000014", irq_take, Cause); end
    instr_boundary = 1'b0; eret = 1'b1; irq_in = '0;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_no_nesting();
    do_reset();
    set_mask(8'hFF);
    irq_in[4] = 1'b1;
    repeat (3) tick();
    instr_boundary = 1'b1; PC = 32'h0000_0100;
    tick();
    irq_in[0] = 1'b1; PC = 32'h0000_0180;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (irq_take !== 1'b0) begin
        failures++; $display("FAIL nest_take: cycle %0d got %b want 0", i, irq_take); end
    end
    checks++; if (pending !== 8'h01) begin
      failures++; $display("FAIL nest_pending: got %h want 01", pending); end
    checks++; if (EPC !== 32'h100 || Cause !== 32'h8000_0010) begin
      failures++; $display("FAIL nest_hold: epc=%h cause=%h want 00000100 80000010", EPC, Cause); end
    eret = 1'b1; PC = 32'h0000_0200;
    tick();
    eret = 1'b0;
    checks++; if (irq_take !== 1'b0) begin
      failures++; $display("FAIL nest_eret_edge: got %b want 0", irq_take); end
    tick();
    checks++; if (irq_take !== 1'b1 || Cause !== 32'h8000_0000 || EPC !== 32'h200) begin
      failures++; $display("FAIL nest_retake: take=%b cause=%h epc=%h want 1 80000000 00000200",
                           irq_take, Cause, EPC); end
    instr_boundary = 1'b0; irq_in = '0;
  endtask

  task automatic test_set_wins();
    do_reset();
    set_mask(8'hFF);
    irq_in[2] = 1'b1;
    repeat (3) tick();
    irq_in[2] = 1'b0;
    tick();
    irq_in[2] = 1'b1;
    tick(); tick();
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0;
    checks++; if (irq_take !== 1'b1 || Cause !== 32'h8000_0008 || pending !== 8'h04) begin
      failures++; $display("FAIL setwins: take=%b cause=%h pend=%h want 1 80000008 04",
                           irq_take, Cause, pending); end
    eret = 1'b1; mask_wr = 1'b1; mask_data = 8'h00;
    tick();
    eret = 1'b0; mask_wr = 1'b0; instr_boundary = 1'b1;
    checks++; if (in_service !== 1'b0) begin
      failures++; $display("FAIL eret_mask_svc: got %b want 0", in_service); end
    tick();
    checks++; if (irq_take !== 1'b0 || pending !== 8'h04) begin
      failures++; $display("FAIL eret_mask_take: take=%b pend=%h want 0 04", irq_take, pending); end
    instr_boundary = 1'b0; irq_in = '0;
  endtask

  task automatic test_mask_old();
    do_reset();
    irq_in[1] = 1'b1;
    repeat (3) tick();
    instr_boundary = 1'b1; mask_wr = 1'b1; mask_data = 8'hFF;
    tick();
    mask_wr = 1'b0;
    checks++; if (irq_take !== 1'b0 || pending !== 8'h02) begin
      failures++; $display("FAIL mask_old: take=%b pend=%h want 0 02", irq_take, pending); end
    tick();
    checks++; if (irq_take !== 1'b1 || Cause !== 32'h8000_0004) begin
      failures++; $display("FAIL mask_new: take=%b cause=%h want 1 80000004", irq_take, Cause); end
    instr_boundary = 1'b0; irq_in = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_mask(8'hFF);
    irq_in[6] = 1'b1;
    repeat (3) tick();
    instr_boundary = 1'b1; PC = 32'h0000_1234;
    tick();
    irq_in[1] = 1'b1;
    repeat (3) tick();
    checks++; if (in_service !== 1'b1 || pending !== 8'h02) begin
      failures++; $display("FAIL areset_pre: svc=%b pend=%h want 1 02", in_service, pending); end
    #3 reset = 1'b0;
    #1;
    checks++; if ({in_service, irq_take, EPC, Cause, pending} !== '0) begin
      failures++; $display("FAIL areset_clear: svc=%b take=%b epc=%h cause=%h pend=%h want all 0",
                           in_service, irq_take, EPC, Cause, pending); end
    irq_in = '0; instr_boundary = 1'b0;
    m_clear();
    @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_vector();
    logic [31:0] want;
`ifdef IRQ_VECTORED_EN
    want = 32'h0000_00E0;
`else
    want = 32'h0000_00C0;
`endif
    do_reset();
    set_mask(8'hFF);
    irq_in[2] = 1'b1;
    repeat (3) tick();
    instr_boundary = 1'b1;
    tick();
    instr_boundary = 1'b0; irq_in = '0;
    checks++; if (irq_take !== 1'b1 || irq_vector !== want) begin
      failures++; $display("FAIL vector: take=%b vec=%h want 1 %h", irq_take, irq_vector, want); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      irq_in         = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      instr_boundary = 1'($urandom_range(0, 1));
      eret           = ($urandom_range(0, 5) == 0);
      mask_wr        = ($urandom_range(0, 9) == 0);
      mask_data      = 8'($urandom);
      PC             = $urandom & 32'hFFFF_FFFC;
      tick();
      checks++; if (irq_take !== m_take || in_service !== m_svc) begin
        failures++; $display("FAIL rand_ctrl: cycle %0d take=%b svc=%b want %b %b",
                             c, irq_take, in_service, m_take, m_svc); end
      checks++; if (pending !== m_pend) begin
        failures++; $display("FAIL rand_pending: cycle %0d got %h want %h", c, pending, m_pend); end
      checks++; if (EPC !== m_epc || Cause !== m_cause) begin
        failures++; $display("FAIL rand_capture: cycle %0d epc=%h cause=%h want %h %h",
                             c, EPC, Cause, m_epc, m_cause); end
      checks++; if (irq_vector !== m_vec()) begin
        failures++; $display("FAIL rand_vector: cycle %0d got %h want %h", c, irq_vector, m_vec()); end
    end
    eret = 1'b0; mask_wr = 1'b0; instr_boundary = 1'b0; irq_in = '0;
  endtask

  initial begin
    m_clear();
    test_reset();
    test_basic_take();
    test_priority();
    test_no_nesting();
    test_set_wins();
    test_mask_old();
    test_async_reset();
    test_vector();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
